// File: rtl/systolic_job_dispatcher.sv
// systolic_job_dispatcher
// Host-side initiator for the systolic matmul controller start/done handshake.
// Buffers job descriptors in a small FIFO, presents the head job on the held
// cfg_* bus, launches with a start pulse, acknowledges done with a second
// start pulse and returns per-job status on a valid/ready port.
// Optional watchdog: define DISPATCH_TIMEOUT_EN to abort jobs whose done
// never arrives within TIMEOUT cycles.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for a queued job and no unconsumed status
// S_LOAD      | head job popped into cfg_*, busy asserted
// S_LAUNCH    | start pulse, cycle counter and error latch cleared
// S_WAIT_DONE | counting cycles, latching err_found, waiting for done
// S_ACK       | acknowledge start pulse
// S_WAIT_CLR  | waiting for the controller to drop done
// S_REPORT    | status registers loaded, sts_valid raised
module systolic_job_dispatcher #(
    parameter int DIM_W   = 8,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ID_W-1:0]   job_id,
    input  logic [DIM_W-1:0]  job_m,
    input  logic [DIM_W-1:0]  job_n,
    input  logic [DIM_W-1:0]  job_k,
    input  logic [ADDR_W-1:0] job_bai1,
    input  logic [ADDR_W-1:0] job_bai2,
    input  logic [ADDR_W-1:0] job_bao,
    output logic [DIM_W-1:0]  cfg_m,
    output logic [DIM_W-1:0]  cfg_n,
    output logic [DIM_W-1:0]  cfg_k,
    output logic [ADDR_W-1:0] cfg_bai1,
    output logic [ADDR_W-1:0] cfg_bai2,
    output logic [ADDR_W-1:0] cfg_bao,
    output logic              start,
    input  logic              done,
    input  logic              err_found,
    output logic              busy,
    output logic              sts_valid,
    input  logic              sts_ready,
    output logic [ID_W-1:0]   sts_id,
    output logic              sts_err,
    output logic              sts_timeout,
    output logic [CNT_W-1:0]  sts_cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_WAIT_DONE, S_ACK, S_WAIT_CLR, S_REPORT
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DIM_W-1:0]  m;
        logic [DIM_W-1:0]  n;
        logic [DIM_W-1:0]  k;
        logic [ADDR_W-1:0] bai1;
        logic [ADDR_W-1:0] bai2;
        logic [ADDR_W-1:0] bao;
    } desc_t;

    state_t           state_q, state_d;
    desc_t            mem [DEPTH];
    desc_t            head;
    logic [PW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [ID_W-1:0]  cur_id;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;
    logic             to_q, to_d;
    logic             sts_load;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign job_ready = !full;
    assign push      = job_valid && !full;
    assign head      = mem[rd_ptr[PW-1:0]];

`ifndef DISPATCH_TIMEOUT_EN
    // The watchdog limit has no consumer when the watchdog is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_C;
`endif

    // Next-state and datapath-next logic for the dispatch sequence.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        to_d     = to_q;
        sts_load = 1'b0;
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                if (!empty && !sts_valid) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:   state_d = S_LAUNCH;
            S_LAUNCH: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                to_d    = 1'b0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_inc;
                err_d = err_q | err_found;
                // done wins over a watchdog expiry in the same cycle
                if (done) begin
                    state_d = S_ACK;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (cnt_inc >= TIMEOUT_C) begin
                    to_d    = 1'b1;
                    state_d = S_ACK;
                end
`endif
            end
            S_ACK: begin
                // after a watchdog abort done may never drop, so skip the wait
                state_d = to_q ? S_REPORT : S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (!done) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                sts_load = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and registered start/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start   <= 1'b0;
            busy    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start   <= (state_d == S_LAUNCH) || (state_d == S_ACK);
            busy    <= state_d inside {S_LOAD, S_LAUNCH, S_WAIT_DONE, S_ACK, S_WAIT_CLR};
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // Descriptor storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= '{id: job_id, m: job_m, n: job_n, k: job_k,
                                     bai1: job_bai1, bai2: job_bai2, bao: job_bao};
        end
    end

    // FIFO pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Held configuration bus, updated only when a job is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_m    <= '0;
            cfg_n    <= '0;
            cfg_k    <= '0;
            cfg_bai1 <= '0;
            cfg_bai2 <= '0;
            cfg_bao  <= '0;
            cur_id   <= '0;
        end else if (pop) begin
            cfg_m    <= head.m;
            cfg_n    <= head.n;
            cfg_k    <= head.k;
            cfg_bai1 <= head.bai1;
            cfg_bai2 <= head.bai2;
            cfg_bao  <= head.bao;
            cur_id   <= head.id;
        end
    end

    // Status port: loaded on report, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_valid   <= 1'b0;
            sts_id      <= '0;
            sts_err     <= 1'b0;
            sts_timeout <= 1'b0;
            sts_cycles  <= '0;
        end else if (sts_load) begin
            sts_valid   <= 1'b1;
            sts_id      <= cur_id;
            sts_err     <= err_q | to_q;
            sts_timeout <= to_q;
            sts_cycles  <= cnt_q;
        end else if (sts_valid && sts_ready) begin
            sts_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_job_dispatcher.sv
// Testbench for systolic_job_dispatcher: random and directed jobs, a
// behavioural controller model, and a status scoreboard.
`timescale 1ns/1ps
module tb_systolic_job_dispatcher;
    localparam int DIM_W = 8, ADDR_W = 16, DEPTH = 4, ID_W = 4, CNT_W = 24;
`ifdef DISPATCH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
    localparam bit TO_EN      = 1'b1;
`else
    localparam int TB_TIMEOUT = 1000000;
    localparam bit TO_EN      = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic job_valid = 1'b0;
    logic job_ready;
    logic [ID_W-1:0] job_id = '0;
    logic [DIM_W-1:0] job_m = '0, job_n = '0, job_k = '0;
    logic [ADDR_W-1:0] job_bai1 = '0, job_bai2 = '0, job_bao = '0;
    logic [DIM_W-1:0] cfg_m, cfg_n, cfg_k;
    logic [ADDR_W-1:0] cfg_bai1, cfg_bai2, cfg_bao;
    logic start, busy, sts_valid, sts_err, sts_timeout;
    logic done = 1'b0, err_found = 1'b0, sts_ready = 1'b0;
    logic [ID_W-1:0] sts_id;
    logic [CNT_W-1:0] sts_cycles;

    systolic_job_dispatcher #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W),
                              .CNT_W(CNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_id(job_id), .job_m(job_m), .job_n(job_n), .job_k(job_k),
        .job_bai1(job_bai1), .job_bai2(job_bai2), .job_bao(job_bao),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .cfg_bai1(cfg_bai1), .cfg_bai2(cfg_bai2), .cfg_bao(cfg_bao),
        .start(start), .done(done), .err_found(err_found), .busy(busy),
        .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_id(sts_id), .sts_err(sts_err),
        .sts_timeout(sts_timeout), .sts_cycles(sts_cycles));

    always #5 clk = ~clk;

    // delay: cycles from launch to done (0 = never); err_at: cycle after launch
    // when err_found pulses (<0 = never); clr: extra cycles done stays high after ack
    typedef struct {
        int delay; int err_at; int clr;
        logic [ID_W-1:0] id;
        logic [DIM_W-1:0] m, n, k;
        logic [ADDR_W-1:0] b1, b2, bo;
    } job_t;
    typedef struct {
        logic [ID_W-1:0] id; logic err; logic to; logic [CNT_W-1:0] cycles;
    } sts_t;

    job_t ctl_q[$];
    sts_t exp_q[$];
    int checks = 0, errors = 0;
    int sr_mode = 2;          // 0 random, 1 held low, 2 held high
    bit noise_on = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required at %0t", name, $time);
    endfunction

    // Reference: status a job must produce, from the job's timing alone.
    function automatic sts_t expect_of(input job_t j);
        sts_t s;
        bit to;
        int eff;
        to = TO_EN && (j.delay == 0 || j.delay > TB_TIMEOUT);
        eff = to ? TB_TIMEOUT : j.delay;
        s.id = j.id;
        s.to = to;
        s.err = to || (j.err_at >= 1 && j.err_at <= eff);
        s.cycles = CNT_W'(eff);
        return s;
    endfunction

    function automatic job_t mk_job(input int id, input int m, input int n, input int k,
                                    input int b1, input int b2, input int bo,
                                    input int delay, input int err_at, input int clr);
        job_t j;
        j.id = ID_W'(id); j.m = DIM_W'(m); j.n = DIM_W'(n); j.k = DIM_W'(k);
        j.b1 = ADDR_W'(b1); j.b2 = ADDR_W'(b2); j.bo = ADDR_W'(bo);
        j.delay = delay; j.err_at = err_at; j.clr = clr;
        return j;
    endfunction

    // Offer one descriptor; returns at posedge+1 after acceptance, job_valid left high.
    task automatic push_job(input job_t j, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        job_id = j.id; job_m = j.m; job_n = j.n; job_k = j.k;
        job_bai1 = j.b1; job_bai2 = j.b2; job_bao = j.bo;
        job_valid = 1'b1;
        while (!got && waited < 3000) begin
            @(negedge clk);
            if (job_ready) begin
                got = 1'b1;
                ctl_q.push_back(j);
                exp_q.push_back(expect_of(j));
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (!got) fail_now("push_accept");
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ctl_q.size() != 0 || busy || sts_valid) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) fail_now(name);
    endtask

    // Status consumer readiness.
    always @(posedge clk) begin
        #1;
        case (sr_mode)
            0:       sts_ready = 1'($urandom_range(0, 1));
            1:       sts_ready = 1'b0;
            default: sts_ready = 1'b1;
        endcase
    end

    // Controller model and output monitor, both on the falling edge.
    job_t cur;
    bit in_job = 1'b0, start_prev = 1'b0, hold_v = 1'b0;
    int kcnt = 0, clr_cnt = 0, pulse_cnt = 0;
    sts_t held, e;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_job = 1'b0; kcnt = 0; clr_cnt = 0; done = 1'b0; err_found = 1'b0;
            pulse_cnt = 0; start_prev = 1'b0; hold_v = 1'b0;
        end else begin
            err_found = 1'b0;
            if (start) begin
                pulse_cnt++;
                check("start_one_cycle", 64'(start_prev), 64'd0);
                check("start_while_sts_pending", 64'(sts_valid), 64'd0);
            end
            if (start && !in_job) begin
                if (ctl_q.size() == 0) begin
                    fail_now("unexpected_launch");
                end else begin
                    cur = ctl_q.pop_front();
                    in_job = 1'b1; kcnt = 0; done = 1'b0;
                    if (cur.err_at == 0) err_found = 1'b1;
                    check("cfg_dims_launch", 64'({cfg_m, cfg_n, cfg_k}), 64'({cur.m, cur.n, cur.k}));
                    check("cfg_addr_launch", 64'({cfg_bai1, cfg_bai2, cfg_bao}), 64'({cur.b1, cur.b2, cur.bo}));
                    check("busy_launch", 64'(busy), 64'd1);
                end
            end else if (start && in_job) begin
                in_job = 1'b0;
                clr_cnt = cur.clr;
                if (clr_cnt == 0) done = 1'b0;
            end else if (in_job) begin
                check("cfg_hold", 64'({cfg_m, cfg_n, cfg_k, cfg_bai1[7:0], cfg_bai2[7:0], cfg_bao[7:0]}),
                      64'({cur.m, cur.n, cur.k, cur.b1[7:0], cur.b2[7:0], cur.bo[7:0]}));
                check("busy_in_flight", 64'(busy), 64'd1);
                kcnt++;
                if (cur.delay != 0 && kcnt == cur.delay) done = 1'b1;
                if (kcnt == cur.err_at) err_found = 1'b1;
            end else if (clr_cnt > 0) begin
                clr_cnt--;
                if (clr_cnt == 0) done = 1'b0;
            end else if (noise_on) begin
                done = 1'b1;
                err_found = 1'b1;
            end else begin
                done = 1'b0;
            end

            if (sts_valid) begin
                if (hold_v)
                    check("sts_stable", 64'({sts_id, sts_err, sts_timeout, sts_cycles}),
                          64'({held.id, held.err, held.to, held.cycles}));
                if (sts_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_status");
                    end else begin
                        e = exp_q.pop_front();
                        check("sts_id", 64'(sts_id), 64'(e.id));
                        check("sts_err", 64'(sts_err), 64'(e.err));
                        check("sts_timeout", 64'(sts_timeout), 64'(e.to));
                        check("sts_cycles", 64'(sts_cycles), 64'(e.cycles));
                        check("start_pulses_per_job", 64'(pulse_cnt), 64'd2);
                    end
                    pulse_cnt = 0;
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    held.id = sts_id; held.err = sts_err; held.to = sts_timeout; held.cycles = sts_cycles;
                end
            end else begin
                hold_v = 1'b0;
            end
            start_prev = start;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int w, n, d;
        job_t j;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 64'(start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sts_valid", 64'(sts_valid), 64'd0);
        check("rst_sts_fields", 64'({sts_id, sts_err, sts_timeout, sts_cycles}), 64'd0);
        check("rst_cfg_dims", 64'({cfg_m, cfg_n, cfg_k}), 64'd0);
        check("rst_cfg_addr", 64'({cfg_bai1, cfg_bai2, cfg_bao}), 64'd0);
        check("rst_job_ready", 64'(job_ready), 64'd1);
        rst_n = 1'b1;

        // done/err_found while idle must not launch anything
        noise_on = 1'b1;
        repeat (4) @(posedge clk);
        #1 noise_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_done_no_start", 64'(pulse_cnt), 64'd0);
        check("idle_done_not_busy", 64'(busy), 64'd0);

        // single job
        push_job(mk_job(3, 4, 4, 4, 16'h0000, 16'h0100, 16'h0200, 40, -1, 1), w);
        job_valid = 1'b0;
        wait_drain("drain_single");

        // error path
        push_job(mk_job(5, 2, 3, 4, 16'h1000, 16'h2000, 16'h3000, 3, 1, 0), w);
        job_valid = 1'b0;
        wait_drain("drain_error");

        // FIFO fill with job 0 in flight
        push_job(mk_job(0, 8, 8, 8, 16'h0010, 16'h0020, 16'h0030, 60, -1, 0), w);
        job_valid = 1'b0;
        n = 0;
        while (!in_job && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) fail_now("fill_first_launch");
        for (int i = 1; i <= 4; i++) begin
            push_job(mk_job(i, i, i + 1, i + 2, i * 16, i * 32, i * 64, 5 + i, -1, 0), w);
            check("fill_no_wait", 64'(w), 64'd0);
        end
        job_valid = 1'b0;
        @(negedge clk);
        check("fill_job_ready_low", 64'(job_ready), 64'd0);
        @(posedge clk); #1;
        wait_drain("drain_fill");

        // status backpressure
        sr_mode = 1;
        push_job(mk_job(0, 1, 1, 1, 1, 2, 3, 10, -1, 0), w);
        push_job(mk_job(1, 2, 2, 2, 4, 5, 6, 5, 2, 0), w);
        job_valid = 1'b0;
        n = 0;
        while (!sts_valid && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) fail_now("bp_first_status");
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_launch", 64'(pulse_cnt), 64'd2);
        check("bp_still_valid", 64'(sts_valid), 64'd1);
        sr_mode = 2;
        wait_drain("drain_bp");

        // randomized jobs with random status backpressure
        sr_mode = 0;
        for (int i = 0; i < 25; i++) begin
            d = $urandom_range(1, 30);
            j = mk_job($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 65535),
                       $urandom_range(0, 65535), d,
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, d + 2) : -1,
                       $urandom_range(0, 3));
            push_job(j, w);
            if ($urandom_range(0, 2) == 0) begin
                job_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        job_valid = 1'b0;
        wait_drain("drain_random");
        sr_mode = 2;

        // reset in the middle of a job
        push_job(mk_job(7, 3, 3, 3, 7, 8, 9, 100, -1, 0), w);
        job_valid = 1'b0;
        n = 0;
        while (!in_job && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) fail_now("abort_launch");
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_start", 64'(start), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sts_valid", 64'(sts_valid), 64'd0);
        check("abort_job_ready", 64'(job_ready), 64'd1);
        ctl_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_restart", 64'(pulse_cnt), 64'd0);
        check("abort_no_status", 64'(sts_valid), 64'd0);

`ifdef DISPATCH_TIMEOUT_EN
        // controller never answers
        push_job(mk_job(9, 4, 4, 4, 1, 2, 3, 0, -1, 0), w);
        job_valid = 1'b0;
        wait_drain("drain_timeout");
`endif

        // post-reset operation still works
        push_job(mk_job(12, 5, 6, 7, 16'h0abc, 16'h0def, 16'h0123, 7, 4, 2), w);
        job_valid = 1'b0;
        wait_drain("drain_final");
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
